data_array_nway: RTL
====================

DATA_ARRAY_NWAY -- requirements
Module: data_array_nway

Interface
REQ-001 The module SHALL have parameter S_OFFSET, default 5, meaning log2 of bytes per line (s_mask = 2**S_OFFSET, s_line = 8*s_mask bits).
REQ-002 The module SHALL have parameter S_INDEX, default 3, meaning log2 of sets (num_sets = 2**S_INDEX).
REQ-003 The module SHALL have parameter NUM_WAYS, default 4, meaning ways per set; it is a power of two >= 1, and the way-select width is s_way = max(1, clog2(NUM_WAYS)).
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock, with all state on the rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: the reset, which is asynchronous and active-low (asserted at 0).
REQ-006 The module SHALL have port read, input, 1 bit: read request.
REQ-007 The module SHALL have ports rindex (input, S_INDEX bits) and rway (input, s_way bits): read set and way.
REQ-008 The module SHALL have port write, input, 1 bit: write request.
REQ-009 The module SHALL have ports windex (input, S_INDEX bits) and wway (input, s_way bits): write set and way.
REQ-010 The module SHALL have port wmask, input, s_mask bits: per-byte write enable.
REQ-011 The module SHALL have port datain, input, s_line bits: write data.
REQ-012 The module SHALL have port clear, input, 1 bit: request to zero the whole array.
REQ-013 The module SHALL have port ready, output, 1 bit: high when the array accepts reads and writes.
REQ-014 The module SHALL have port rvalid, output, 1 bit: dataout carries the result of an accepted read.
REQ-015 The module SHALL have port dataout, output, s_line bits: registered read data.

Function
REQ-016 The controller SHALL have two states: INIT (zeroing sweep) and READY; ready SHALL be 1 only in READY.
REQ-017 In INIT, each cycle SHALL write zero to every way of set sweep_ctr and increment sweep_ctr; the cycle that writes set num_sets-1 SHALL transition to READY.
REQ-018 A full sweep SHALL take exactly num_sets cycles, with ready rising on the edge after the last set is zeroed.
REQ-019 clear in READY SHALL transition to INIT with sweep_ctr=0; clear in INIT SHALL restart the sweep at sweep_ctr=0.
REQ-020 A read SHALL be accepted when read=1, ready=1 and clear=0; a write SHALL be accepted when write=1, ready=1 and clear=0.
REQ-021 Requests while ready=0 SHALL be dropped with no state change and no rvalid.
REQ-022 An accepted write SHALL update, at the edge, only bytes i of line [windex][wway] where wmask[i]=1.
REQ-023 An accepted read SHALL load dataout at the edge with line [rindex][rway], and rvalid SHALL be 1 in the following cycle only (1-cycle latency).
REQ-024 When an accepted read and write hit the same rindex/windex and rway/wway, byte i of dataout SHALL be datain byte i if wmask[i]=1, else the stored byte (write-first forwarding).
REQ-025 There SHALL be no forwarding across different ways or sets; the read SHALL return the pre-write contents.
REQ-026 Without an accepted read, rvalid SHALL be 0 and dataout SHALL hold its last value.
REQ-027 clear SHALL take priority over simultaneous read/write: both are ignored and rvalid is 0 next cycle.
REQ-028 Back-to-back accepted reads SHALL be sustained at one per cycle with rvalid continuously high.

Reset
REQ-029 While rst=0, state SHALL be INIT, sweep_ctr=0, ready=0, rvalid=0 and dataout=0, regardless of clk.
REQ-030 Array storage SHALL NOT be asynchronously reset; it is zeroed by the INIT sweep that starts on the first edge after rst deasserts.
REQ-031 rst asserted mid-sweep or mid-read SHALL abandon the operation; no rvalid pulse SHALL follow reset deassertion.

Verification
REQ-032 Release rst -> ready=0 for 8 cycles, then 1; reading all 8 sets x 4 ways -> dataout=0, rvalid=1 each cycle.
REQ-033 Write set 3 way 2 wmask=0x0000000F datain all 0xAA, then read it -> bytes 0-3 = 0xAA, bytes 4-31 = 0x00, rvalid high for one cycle.
REQ-034 Same-cycle write and read of set 5 way 1 with wmask=0xFFFF0000, datain all 0x55, old line all 0x11 -> dataout bytes 16-31 = 0x55, bytes 0-15 = 0x11.
REQ-035 Same-cycle write of set 5 way 1 and read of set 5 way 0 -> dataout equals the old way-0 line.
REQ-036 Assert clear together with read after writing data -> rvalid=0, ready low for 8 cycles, and all lines then read 0.
REQ-037 Assert rst during cycle 4 of the sweep -> ready=0 and dataout=0 immediately; after release, the full 8-cycle sweep restarts.

Source files
------------

// File: rtl/data_array_nway.sv
// -----------------------------------------------------------------------------
// data_array_nway
//
// N-way set-associative line store for a cache data array. Each line is
// 2**S_OFFSET bytes and can be written one byte at a time under a byte mask.
// Reads are registered and have one cycle of latency. A read that hits the
// same set and way as a same-cycle write returns the merged (write-first) line.
//
// After reset, and whenever clear is raised, the controller sweeps the array
// one set per cycle and zeroes every way of that set. Reads and writes are
// accepted only once the sweep has finished (ready=1).
//
// Ports
//   clk      : clock; all state changes on the rising edge
//   rst      : asynchronous reset, active low
//   read     : read request
//   rindex   : set to read
//   rway     : way to read
//   write    : write request
//   windex   : set to write
//   wway     : way to write
//   wmask    : per-byte write enable
//   datain   : write data
//   clear    : zero the whole array (takes priority over read/write)
//   ready    : array is accepting reads and writes
//   rvalid   : dataout holds the result of the read accepted last cycle
//   dataout  : registered read data
// -----------------------------------------------------------------------------
module data_array_nway #(
    parameter int S_OFFSET = 5,
    parameter int S_INDEX  = 3,
    parameter int NUM_WAYS = 4,
    localparam int S_MASK   = 2 ** S_OFFSET,
    localparam int S_LINE   = 8 * S_MASK,
    localparam int NUM_SETS = 2 ** S_INDEX,
    localparam int S_WAY    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read,
    input  logic [S_INDEX-1:0] rindex,
    input  logic [S_WAY-1:0]  rway,
    input  logic              write,
    input  logic [S_INDEX-1:0] windex,
    input  logic [S_WAY-1:0]  wway,
    input  logic [S_MASK-1:0] wmask,
    input  logic [S_LINE-1:0] datain,
    input  logic              clear,
    output logic              ready,
    output logic              rvalid,
    output logic [S_LINE-1:0] dataout
);

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    state_t              state, state_next;
    logic [S_INDEX-1:0]  sweep_ctr, ctr_next;
    logic                sweep_en;
    logic                rd_acc;
    logic                wr_acc;
    logic                same_line;
    logic [S_LINE-1:0]   rd_line;

    // NOTE: the line store has no reset; it is cleared by the INIT sweep,
    // which keeps it mappable onto plain RAM without a reset port.
    logic [S_LINE-1:0]   mem [NUM_SETS][NUM_WAYS];

    assign ready     = (state == READY);
    assign rd_acc    = read  & ready & ~clear;
    assign wr_acc    = write & ready & ~clear;
    assign same_line = wr_acc && (windex == rindex) && (wway == rway);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= INIT;
            sweep_ctr <= '0;
        end else begin
            state     <= state_next;
            sweep_ctr <= ctr_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        ctr_next   = '0;
        sweep_en   = 1'b0;
        case (state)
            INIT: begin
                sweep_en = 1'b1;
                ctr_next = sweep_ctr + 1'b1;
                if (sweep_ctr == '1) begin
                    state_next = READY;
                end
            end
            READY: begin
                ctr_next = '0;
            end
            default: begin
                state_next = INIT;
            end
        endcase
        // clear overrides everything, including a sweep already in progress.
        if (clear) begin
            state_next = INIT;
            ctr_next   = '0;
        end
    end

    // Read path: stored line, with bytes being written this cycle to the
    // very same set/way substituted in (write-first). Other ways/sets see
    // the pre-write contents.
    always_comb begin
        rd_line = mem[rindex][rway];
        if (same_line) begin
            for (int i = 0; i < S_MASK; i++) begin
                if (wmask[i]) begin
                    rd_line[8*i +: 8] = datain[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sweep_en) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                mem[sweep_ctr][w] <= '0;
            end
        end else if (wr_acc) begin
            for (int i = 0; i < S_MASK; i++) begin
                if (wmask[i]) begin
                    mem[windex][wway][8*i +: 8] <= datain[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid  <= 1'b0;
            dataout <= '0;
        end else begin
            rvalid <= rd_acc;
            if (rd_acc) begin
                dataout <= rd_line;
            end
        end
    end

endmodule
